// File: rtl/fractal_sync_endpoint.sv
// Per-core barrier endpoint: turns a held core request into one sync pulse toward a
// fractal_sync_1d node and matches the node response. Optional WAIT timeout: FRACTAL_SYNC_ENDPOINT_TIMEOUT_EN.
module fractal_sync_endpoint #(
    parameter int unsigned AGGREGATE_WIDTH = 1,
    parameter int unsigned ID_WIDTH        = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       bar_req_i,
    input  logic [AGGREGATE_WIDTH-1:0] bar_aggr_i,
    input  logic [ID_WIDTH-1:0]        bar_id_i,
    output logic                       bar_gnt_o,
    output logic                       bar_wake_o,
    output logic                       bar_error_o,
    output logic                       busy_o,
    output logic                       req_sync_o,
    output logic [AGGREGATE_WIDTH-1:0] req_aggr_o,
    output logic [ID_WIDTH-1:0]        req_id_o,
    input  logic                       rsp_wake_i,
    input  logic                       rsp_error_i,
    input  logic [AGGREGATE_WIDTH-1:0] rsp_aggr_i,
    input  logic [ID_WIDTH-1:0]        rsp_id_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                     state_q;
    logic [AGGREGATE_WIDTH-1:0] aggr_q;
    logic [ID_WIDTH-1:0]        id_q;
    logic                       gnt_q;
    logic                       wake_q;
    logic                       error_q;
    logic                       busy_q;
    logic                       sync_q;
    logic [AGGREGATE_WIDTH-1:0] req_aggr_q;
    logic [ID_WIDTH-1:0]        req_id_q;
    logic                       rsp_match;
    logic                       rsp_any;

`ifdef FRACTAL_SYNC_ENDPOINT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q;
`endif

    assign rsp_match = (rsp_id_i == id_q) && (rsp_aggr_i == aggr_q);
    assign rsp_any   = rsp_wake_i | rsp_error_i;

    // Core side: bar_req_i is held with stable aggr/id until the one-cycle bar_gnt_o; a
    // request seen while busy is simply not granted. Node side: req_sync_o and rsp_*_i are
    // single-cycle pulses with no backpressure.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            aggr_q     <= '0;
            id_q       <= '0;
            gnt_q      <= 1'b0;
            wake_q     <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            sync_q     <= 1'b0;
            req_aggr_q <= '0;
            req_id_q   <= '0;
`ifdef FRACTAL_SYNC_ENDPOINT_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            gnt_q      <= 1'b0;
            wake_q     <= 1'b0;
            error_q    <= 1'b0;
            sync_q     <= 1'b0;
            req_aggr_q <= '0;
            req_id_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (bar_req_i) begin
                        gnt_q <= 1'b1;
                        if (bar_aggr_i != '0) begin
                            aggr_q  <= bar_aggr_i;
                            id_q    <= bar_id_i;
                            state_q <= ISSUE;
                            busy_q  <= 1'b1;
                        end else begin
                            // An empty level mask can never complete: refuse it at once.
                            error_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    sync_q     <= 1'b1;
                    req_aggr_q <= aggr_q;
                    req_id_q   <= id_q;
                    state_q    <= WAIT;
`ifdef FRACTAL_SYNC_ENDPOINT_TIMEOUT_EN
                    timer_q    <= '0;
`endif
                end
                WAIT: begin
                    if (rsp_match && rsp_any) begin
                        // Node error outranks a simultaneous wake.
                        error_q <= rsp_error_i;
                        wake_q  <= ~rsp_error_i;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (rsp_any) begin
                            error_q <= 1'b1;
                        end
`ifdef FRACTAL_SYNC_ENDPOINT_TIMEOUT_EN
                        if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bar_gnt_o   = gnt_q;
    assign bar_wake_o  = wake_q;
    assign bar_error_o = error_q;
    assign busy_o      = busy_q;
    assign req_sync_o  = sync_q;
    assign req_aggr_o  = req_aggr_q;
    assign req_id_o    = req_id_q;

endmodule
